vc_output_scheduler: RTL

Per-output-port scheduler that shares one router output link among five virtual-channel input buffers. It drives the one-hot select of the 5:1 data/valid mux and issues per-VC pop strobes. Packets are wormhole-locked: a granted VC holds the link until its tail flit leaves. Downstream buffer space is tracked with a credit counter. It sits between the VC buffers and the output mux of each router port.

---
 rtl/vc_output_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vc_output_scheduler.sv
// vc_output_scheduler
// Shares one router output link among five virtual-channel input buffers.
// A round-robin arbiter picks a requesting VC while the scheduler is idle. That VC
// then owns the link (wormhole lock) until its tail flit has been popped.
// A credit counter tracks free slots in the downstream buffer, so no flit is sent
// into a full buffer.
module vc_output_scheduler #(
    parameter int CREDITS = 4,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [4:0]    req,
    input  logic [4:0]    tail,
    input  logic          credit_in,
    output logic [4:0]    mux_sel,
    output logic [4:0]    pop,
    output logic [CW-1:0] credit_cnt,
    output logic          credit_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    state_t        state_q,      state_d;
    logic [2:0]    owner_q,      owner_d;
    logic [4:0]    mux_sel_q,    mux_sel_d;
    logic [2:0]    rr_ptr_q,     rr_ptr_d;
    logic [CW-1:0] credit_cnt_q, credit_cnt_d;
    logic          credit_err_q, credit_err_d;

    logic          arb_found;
    logic [2:0]    arb_winner;
    logic [2:0]    arb_cand;
    logic          owner_go;
    logic          transfer;

    // Adds two indices in 0..4 and wraps the result modulo 5.
    function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

    // Converts a VC index into a one-hot select vector.
    function automatic logic [4:0] onehot5(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

    // Round-robin search: the first requester found when scanning from rr_ptr upward.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = 3'd0;
        arb_cand   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            arb_cand = wrap5(rr_ptr_q, 3'(k));
            if (!arb_found && req[arb_cand]) begin
                arb_found  = 1'b1;
                arb_winner = arb_cand;
            end
        end
    end

    // The owner moves a flit only when it has data and downstream has room.
    always_comb begin
        owner_go = (state_q == LOCKED) && req[owner_q] && (credit_cnt_q != '0);
        pop      = owner_go ? onehot5(owner_q) : 5'b00000;
        transfer = owner_go;
    end

    // Next-state logic for the lock FSM, the mux select and the round-robin pointer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        mux_sel_d = mux_sel_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            IDLE: begin
                mux_sel_d = 5'b00000;
                if (arb_found) begin
                    state_d   = LOCKED;
                    owner_d   = arb_winner;
                    mux_sel_d = onehot5(arb_winner);
                end
            end
            LOCKED: begin
                if (owner_go && tail[owner_q]) begin
                    state_d   = IDLE;
                    mux_sel_d = 5'b00000;
                    rr_ptr_d  = wrap5(owner_q, 3'd1);
                end
            end
            default: begin
                state_d   = IDLE;
                mux_sel_d = 5'b00000;
            end
        endcase
    end

    // Credit bookkeeping. A credit returned while a flit leaves cancels out.
    // A credit arriving when the counter is already full is flagged as an error.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        if (transfer && !credit_in) begin
            credit_cnt_d = credit_cnt_q - 1'b1;
        end else if (!transfer && credit_in) begin
            if (credit_cnt_q == CREDIT_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset. Reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            owner_q      <= 3'd0;
            mux_sel_q    <= 5'b00000;
            rr_ptr_q     <= 3'd0;
            credit_cnt_q <= CREDIT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mux_sel_q    <= mux_sel_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign mux_sel    = mux_sel_q;
    assign credit_cnt = credit_cnt_q;
    assign credit_err = credit_err_q;

endmodule
